// File: rtl/stack_pkg.sv
// Shared types and constants for the operand stack and the control FSM that drives it.
package stack_pkg;

  localparam int STACK_WIDTH = 8;
  localparam int STACK_DEPTH = 8;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MDR = 1'b1;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } stack_op_t;

  function automatic stack_op_t decode_op(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return OP_PUSH;
      2'b01:   return OP_POP;
      2'b11:   return OP_REPLACE;
      default: return OP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
module stack_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // NOTE: always_comb starts from a full default copy so no entry can infer a latch.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // NOTE: the array is cleared on reset because a freshly reset stack must read back all-zero entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/stack_unit.sv
// Operand stack: pointer, push/pop/replace decode and sticky error flags around stack_regfile.
module stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   stack_src,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic [WIDTH-1:0]       mdr_data,
  input  logic                   err_clear,
  output logic [WIDTH-1:0]       tos,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             we;
  logic [PTR_W-1:0] waddr;
  logic [PTR_W-1:0] sp;
  logic [PTR_W-1:0] top_addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  stack_op_t        op;

  // At count == DEPTH the low bits wrap to 0, so top_addr still lands on DEPTH-1.
  assign sp       = count_q[PTR_W-1:0];
  assign top_addr = sp - 1'b1;
  assign wdata    = (stack_src == SRC_MDR) ? mdr_data : alu_result;
  assign op       = decode_op(push, pop);
  assign empty    = (count_q == '0);
  assign full     = (count_q == (PTR_W+1)'(DEPTH));

  always_comb begin
    count_d     = count_q;
    overflow_d  = err_clear ? 1'b0 : overflow_q;
    underflow_d = err_clear ? 1'b0 : underflow_q;
    we          = 1'b0;
    waddr       = sp;
    case (op)
      OP_PUSH: begin
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          we      = 1'b1;
          count_d = count_q + 1'b1;
        end
      end
      OP_POP: begin
        if (empty) underflow_d = 1'b1;
        else       count_d     = count_q - 1'b1;
      end
      OP_REPLACE: begin
        we = 1'b1;
        if (empty) begin
          // Replace on an empty stack degrades to a push into entry 0.
          underflow_d = 1'b1;
          count_d     = count_q + 1'b1;
        end else begin
          waddr = top_addr;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (top_addr),
    .rdata (rdata)
  );

  assign tos       = empty ? '0 : rdata;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
